// File: rtl/agc_shift_ctrl.sv
// Automatic gain control for the 32-bit DDC output path.
// Tracks per-period peak magnitudes and adjusts a truncation shift with hysteresis.
// Applies that shift to the sample stream, producing saturated 16-bit output.
// Two-stage datapath: arithmetic shift, then saturation to 16 bits.
module agc_shift_ctrl #(
    parameter int unsigned SHIFT_INIT = 8,
    parameter int unsigned SHIFT_MAX  = 20,
    parameter int unsigned HI_THR     = 32'h0000_6000,
    parameter int unsigned LO_THR     = 32'h0000_1000,
    parameter int unsigned UP_CNT     = 2,
    parameter int unsigned DN_CNT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [31:0] peak_in,
    input  logic        peak_valid,
    input  logic        agc_en,
    input  logic [4:0]  manual_shift,
    output logic [15:0] dout,
    output logic        sat,
    output logic [4:0]  shift,
    output logic [1:0]  agc_state
);

    localparam int unsigned CntMax = (UP_CNT > DN_CNT) ? UP_CNT : DN_CNT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [4:0]      ShiftMaxL  = 5'(SHIFT_MAX);
    localparam logic [4:0]      ShiftInitL = 5'(SHIFT_INIT);
    localparam logic [CntW-1:0] UpCntL     = CntW'(UP_CNT);
    localparam logic [CntW-1:0] DnCntL     = CntW'(DN_CNT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StEval  = 2'd2,
        StApply = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [4:0]      shift_q, shift_d;
    logic [31:0]     scaled_q, scaled_d;
    logic [CntW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CntW-1:0] lo_cnt_q, lo_cnt_d;

    logic signed [31:0] s1_q;
    logic [15:0]        dout_q, dout_d;
    logic               sat_q, sat_d;

    logic [4:0] manual_clamped;
    logic [4:0] shift_up;
    logic [4:0] shift_dn;

    assign manual_clamped = (manual_shift > ShiftMaxL) ? ShiftMaxL : manual_shift;
    assign shift_up       = (shift_q >= ShiftMaxL) ? ShiftMaxL : shift_q + 5'd1;
    assign shift_dn       = (shift_q == 5'd0) ? 5'd0 : shift_q - 5'd1;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping agc_en always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (!agc_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StTrack;
                StTrack: if (peak_valid) state_d = StEval;
                StEval:  state_d = StApply;
                StApply: state_d = StTrack;
                default: state_d = StIdle;
            endcase
        end
    end

    // Control next-state: peak capture, hysteresis counters and shift update.
    always_comb begin
        shift_d  = shift_q;
        scaled_d = scaled_q;
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (!agc_en) begin
            hi_cnt_d = '0;
            lo_cnt_d = '0;
        end
        unique case (state_q)
            StIdle: begin
                // Manual shift tracks every cycle; TRACK inherits it unchanged.
                shift_d  = manual_clamped;
                hi_cnt_d = '0;
                lo_cnt_d = '0;
            end
            StTrack: begin
                if (agc_en && peak_valid) begin
                    scaled_d = peak_in >> shift_q;
                end
            end
            StEval: begin
                if (agc_en) begin
                    if (scaled_q > HI_THR) begin
                        hi_cnt_d = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + 1'b1;
                        lo_cnt_d = '0;
                    end else if (scaled_q < LO_THR) begin
                        lo_cnt_d = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + 1'b1;
                        hi_cnt_d = '0;
                    end else begin
                        hi_cnt_d = '0;
                        lo_cnt_d = '0;
                    end
                end
            end
            StApply: begin
                // An abort in APPLY discards the pending update.
                if (agc_en) begin
                    if (hi_cnt_q == UpCntL) begin
                        shift_d  = shift_up;
                        hi_cnt_d = '0;
                        lo_cnt_d = '0;
                    end else if (lo_cnt_q == DnCntL) begin
                        shift_d  = shift_dn;
                        hi_cnt_d = '0;
                        lo_cnt_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= ShiftInitL;
            scaled_q <= '0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            shift_q  <= shift_d;
            scaled_q <= scaled_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    // Saturate the shifted sample to signed 16 bits.
    always_comb begin
        dout_d = s1_q[15:0];
        sat_d  = 1'b0;
        if (!s1_q[31] && (s1_q[30:15] != '0)) begin
            dout_d = 16'h7FFF;
            sat_d  = 1'b1;
        end else if (s1_q[31] && (s1_q[30:15] != '1)) begin
            dout_d = 16'h8000;
            sat_d  = 1'b1;
        end
    end

    // Datapath pipeline; each sample keeps the shift it was launched with.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            s1_q   <= $signed(din) >>> shift_q;
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    // Outputs.
    always_comb begin
        dout      = dout_q;
        sat       = sat_q;
        shift     = shift_q;
        agc_state = state_q;
    end

endmodule

// File: tb/tb_agc_shift_ctrl.sv
// Scoreboard bench for agc_shift_ctrl: stimulus queues expectations tagged with
// the cycle they are due; a negedge monitor compares and retires them.
// A second instance with SHIFT_MAX=16 exercises the upper clamp with real high peaks.
module tb_agc_shift_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [31:0] peak_in;
    logic        peak_valid;
    logic        agc_en;
    logic [4:0]  manual_shift;
    logic [15:0] dout, dout2;
    logic        sat, sat2;
    logic [4:0]  shift, shift2;
    logic [1:0]  agc_state, agc_state2;

    always #5 clk = ~clk;

    agc_shift_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .peak_in      (peak_in),
        .peak_valid   (peak_valid),
        .agc_en       (agc_en),
        .manual_shift (manual_shift),
        .dout         (dout),
        .sat          (sat),
        .shift        (shift),
        .agc_state    (agc_state)
    );

    agc_shift_ctrl #(.SHIFT_MAX(16)) u_dut_max16 (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .peak_in      (peak_in),
        .peak_valid   (peak_valid),
        .agc_en       (agc_en),
        .manual_shift (manual_shift),
        .dout         (dout2),
        .sat          (sat2),
        .shift        (shift2),
        .agc_state    (agc_state2)
    );

    typedef struct {
        int unsigned at;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    localparam int KDout = 0, KSat = 1, KShift = 2, KState = 3, KShift16 = 4;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            KDout:   return {16'h0, dout};
            KSat:    return {31'h0, sat};
            KShift:  return {27'h0, shift};
            KState:  return {30'h0, agc_state};
            default: return {27'h0, shift2};
        endcase
    endfunction

    // Monitor: retire every expectation due in the current cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                act = observe(sb_q[i].kind);
                checks++;
                if (act !== sb_q[i].val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             sb_q[i].name, act, sb_q[i].val, cyc);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned ofs, input int kind, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.at   = cyc + ofs;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One peak strobe followed by two idle cycles; the resulting shift is due 3 clk later.
    task automatic strobe_chk(input logic [31:0] pk, input int kind, input logic [4:0] exp_sh,
                              input string name);
        expect_at(3, kind, {27'h0, exp_sh}, name);
        peak_in    = pk;
        peak_valid = 1'b1;
        tick();
        peak_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic go_auto(input logic [4:0] m);
        agc_en       = 1'b0;
        manual_shift = m;
        tick();
        tick();
        agc_en = 1'b1;
        tick();
        tick();
    endtask

    logic [31:0] dp_din  [7] = '{32'h0001_2340, 32'h0010_0000, 32'hFFF0_0000, 32'hFFFF_EDCC,
                                 32'h0007_FFF0, 32'h0008_0000, 32'hFFF8_0000};
    logic [15:0] dp_dout [7] = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFEDC,
                                 16'h7FFF, 16'h7FFF, 16'h8000};
    logic        dp_sat  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [31:0] dec_pk [8] = '{32'h0000_0800, 32'h0000_0800, 32'h0000_0800, 32'h0040_0000,
                                32'h0000_0800, 32'h0000_0800, 32'h0000_0800, 32'h0000_0800};
    logic [4:0]  dec_sh [8] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd7};

    initial begin
        rst          = 1'b1;
        din          = '0;
        peak_in      = '0;
        peak_valid   = 1'b0;
        agc_en       = 1'b0;
        manual_shift = 5'd4;

        // Reset with random samples on the bus.
        repeat (3) begin
            din = $urandom;
            tick();
        end
        rst = 1'b0;
        din = '0;
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL rst_dout_direct: got %h", dout);
        end
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL rst_sat_direct: got %b", sat);
        end
        checks++;
        if (shift !== 5'd8) begin
            errors++;
            $display("FAIL rst_shift_direct: got %0d", shift);
        end
        checks++;
        if (agc_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_state_direct: got %0d", agc_state);
        end
        expect_at(0, KDout, 32'h0, "rst_dout");
        expect_at(0, KSat, 32'h0, "rst_sat");
        expect_at(0, KShift, 32'd8, "rst_shift");
        expect_at(0, KState, 32'd0, "rst_state");
        tick();
        expect_at(0, KShift, 32'd4, "manual_shift4");

        // Manual datapath at shift 4, including both saturation boundaries.
        for (int i = 0; i < 7; i++) begin
            din = dp_din[i];
            expect_at(2, KDout, {16'h0, dp_dout[i]}, $sformatf("dp_dout%0d", i));
            expect_at(2, KSat, {31'h0, dp_sat[i]}, $sformatf("dp_sat%0d", i));
            tick();
        end
        din          = '0;
        manual_shift = 5'd25;
        expect_at(1, KShift, 32'd20, "manual_clamp20");
        tick();
        din = 32'h7FFF_FFFF;
        expect_at(2, KDout, 32'h0000_07FF, "dp_shift20");
        tick();
        din = '0;
        tick();
        tick();

        // Attack from shift 8.
        go_auto(5'd8);
        expect_at(0, KState, 32'd1, "atk_track");
        expect_at(0, KShift, 32'd8, "atk_start");
        strobe_chk(32'h0080_0000, KShift, 5'd8, "atk1_hold");
        expect_at(1, KState, 32'd2, "atk2_eval");
        expect_at(2, KState, 32'd3, "atk2_apply");
        expect_at(2, KShift, 32'd8, "atk2_shift_pre");
        expect_at(3, KState, 32'd1, "atk2_track");
        strobe_chk(32'h0080_0000, KShift, 5'd9, "atk2_up");
        din = 32'h0001_2340;
        expect_at(2, KDout, 32'h0000_0091, "atk_dp_shift9");
        tick();
        din = '0;
        strobe_chk(32'h0080_0000, KShift, 5'd9, "atk3_mid");

        // peak_valid held through EVAL and APPLY counts only once.
        expect_at(3, KShift, 32'd9, "burst_once");
        peak_in    = 32'h0100_0000;
        peak_valid = 1'b1;
        tick();
        tick();
        tick();
        peak_valid = 1'b0;
        strobe_chk(32'h0100_0000, KShift, 5'd10, "burst_then_up");

        // Decay with hysteresis: a mid-band peak restarts the low count.
        go_auto(5'd8);
        for (int i = 0; i < 8; i++) begin
            strobe_chk(dec_pk[i], KShift, dec_sh[i], $sformatf("decay%0d", i));
        end

        // Lower clamp.
        go_auto(5'd0);
        for (int i = 0; i < 8; i++) begin
            strobe_chk(32'h0000_0800, KShift, 5'd0, $sformatf("clamp_lo%0d", i));
        end

        // Upper clamp on the SHIFT_MAX=16 instance, where full-scale peaks are high.
        go_auto(5'd20);
        expect_at(0, KShift, 32'd20, "clamp_hi_main");
        expect_at(0, KShift16, 32'd16, "clamp_hi_start16");
        for (int i = 0; i < 4; i++) begin
            strobe_chk(32'h7FFF_FFFF, KShift16, 5'd16, $sformatf("clamp_hi%0d", i));
        end

        // Reset in EVAL after the second high strobe discards the increment.
        go_auto(5'd8);
        din = 32'h7FFF_FFFF;
        strobe_chk(32'h0080_0000, KShift, 5'd8, "abort_hi1");
        peak_in    = 32'h0080_0000;
        peak_valid = 1'b1;
        tick();
        expect_at(0, KState, 32'd2, "abort_in_eval");
        expect_at(0, KDout, 32'h0000_7FFF, "abort_pre_dout");
        peak_valid = 1'b0;
        rst        = 1'b1;
        din        = '0;
        tick();
        expect_at(0, KState, 32'd0, "abort_rst_state");
        expect_at(0, KShift, 32'd8, "abort_rst_shift");
        expect_at(0, KDout, 32'h0, "abort_rst_dout");
        expect_at(0, KSat, 32'h0, "abort_rst_sat");
        rst = 1'b0;
        expect_at(1, KState, 32'd1, "abort_retrack");
        expect_at(2, KShift, 32'd8, "abort_no_inc");
        tick();
        tick();
        strobe_chk(32'h0080_0000, KShift, 5'd8, "abort_cnt_cleared");

        // agc_en dropped in APPLY: IDLE next clk, manual shift one clk later.
        peak_in    = 32'h0080_0000;
        peak_valid = 1'b1;
        tick();
        peak_valid = 1'b0;
        tick();
        expect_at(0, KState, 32'd3, "drop_in_apply");
        agc_en       = 1'b0;
        manual_shift = 5'd3;
        expect_at(1, KState, 32'd0, "drop_idle");
        expect_at(2, KShift, 32'd3, "drop_manual");
        repeat (6) tick();

        foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: never compared (due cycle %0d)", sb_q[i].name, sb_q[i].at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
